// File: rtl/accel_apb_bridge.sv
// APB responder bridging CPU transfers to accelerator CTRL/STATUS regs
// and to the accelerator RAM host port (gated while start is set).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   paddr..pwdata        APB request (paddr[12] selects the RAM window)
//   prdata/pready/pslverr APB response
//   start, output_length_byte  control to the accelerator wrapper
//   done, accel_state, accel_error  status from the accelerator wrapper
//   irq                  level interrupt = done_flag & irq_en
//   mem_*                RAM host port; mem_rdata has 1-cycle latency
module accel_apb_bridge #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 13,
  parameter int STATE_W        = 4,
  parameter int ERR_W          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [APB_ADDR_WIDTH-1:0] paddr,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [MEM_DATA_WIDTH-1:0] pwdata,
  output logic [MEM_DATA_WIDTH-1:0] prdata,
  output logic                      pready,
  output logic                      pslverr,
  output logic                      start,
  input  logic                      done,
  output logic                      output_length_byte,
  input  logic [STATE_W-1:0]        accel_state,
  input  logic [ERR_W-1:0]          accel_error,
  output logic                      irq,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]                mem_be,
  output logic [MEM_DATA_WIDTH-1:0] mem_wdata,
  input  logic [MEM_DATA_WIDTH-1:0] mem_rdata
);

  localparam logic ST_IDLE    = 1'b0;
  localparam logic ST_RD_WAIT = 1'b1;

  logic state_q, state_d;
  logic start_q, start_d;
  logic olb_q, olb_d;
  logic irq_en_q, irq_en_d;
  logic flag_q, flag_d;
  logic done_q;

  logic access, in_idle, ram_sel;
  logic reg_ctrl, reg_stat;
  logic ram_ok, ctrl_wr, stat_clr, done_edge;
  logic [MEM_DATA_WIDTH-1:0] ctrl_rd, stat_rd;

  // rst_n gates the request so nothing is issued while in reset
  assign access   = psel & penable & rst_n;
  assign in_idle  = (state_q == ST_IDLE);
  assign ram_sel  = paddr[12];
  assign reg_ctrl = (paddr[11:0] == 12'h000);
  assign reg_stat = (paddr[11:0] == 12'h004);

  assign ram_ok   = access & in_idle & ram_sel & ~start_q;
  assign ctrl_wr  = access & in_idle & ~ram_sel & reg_ctrl
                  & pwrite & ~start_q;
  assign stat_clr = access & in_idle & ~ram_sel & reg_stat
                  & pwrite & pwdata[0];
  assign done_edge = done & ~done_q & start_q;

  assign mem_en    = ram_ok;
  assign mem_we    = ram_ok & pwrite;
  assign mem_addr  = ram_ok ? paddr[MEM_ADDR_WIDTH+1:2] : '0;
  assign mem_be    = ram_ok ? 4'hF : 4'h0;
  assign mem_wdata = (ram_ok & pwrite) ? pwdata : '0;

  always_comb begin
    ctrl_rd    = '0;
    ctrl_rd[0] = start_q;
    ctrl_rd[1] = olb_q;
    ctrl_rd[2] = irq_en_q;
    stat_rd    = '0;
    stat_rd[0] = flag_q;
    stat_rd[1] = start_q;
    stat_rd[8 +: STATE_W] = accel_state;
    stat_rd[16 +: ERR_W]  = accel_error;
  end

  always_comb begin
    state_d = state_q;
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = '0;
    if (state_q == ST_RD_WAIT) begin
      pready  = 1'b1;
      prdata  = mem_rdata;
      state_d = ST_IDLE;
    end else if (access) begin
      if (ram_sel) begin
        if (start_q) begin
          pready  = 1'b1;
          pslverr = 1'b1;
        end else if (pwrite) begin
          pready = 1'b1;
        end else begin
          state_d = ST_RD_WAIT;
        end
      end else begin
        pready = 1'b1;
        unique case (1'b1)
          reg_ctrl: begin
            if (pwrite) pslverr = start_q;
            else        prdata  = ctrl_rd;
          end
          reg_stat: begin
            if (!pwrite) prdata = stat_rd;
          end
          default: pslverr = 1'b1;
        endcase
      end
    end
  end

  // ctrl_wr needs start=0 and done_edge needs start=1: never both
  always_comb begin
    start_d  = start_q;
    olb_d    = olb_q;
    irq_en_d = irq_en_q;
    flag_d   = flag_q;
    if (ctrl_wr) begin
      start_d  = pwdata[0];
      olb_d    = pwdata[1];
      irq_en_d = pwdata[2];
    end
    if (done_edge) start_d = 1'b0;
    if (done_edge)     flag_d = 1'b1;
    else if (stat_clr) flag_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      olb_q    <= 1'b0;
      irq_en_q <= 1'b0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      olb_q    <= olb_d;
      irq_en_q <= irq_en_d;
      flag_q   <= flag_d;
      done_q   <= done;
    end
  end

  assign start              = start_q;
  assign output_length_byte = olb_q;
  assign irq                = flag_q & irq_en_q;

endmodule
